// File: rtl/gshare_predictor_ghr.sv
// gshare direction predictor: speculative global history, snapshot-based recovery,
// and a sweep FSM that initialises the counter table one entry per cycle.
module gshare_predictor_ghr #(
    parameter int XLEN        = 32,
    parameter int PHT_ENTRIES = 1024,
    parameter int GHR_BITS    = 10,
    parameter int CTR_BITS    = 2,
    parameter int CTR_INIT    = 2**(CTR_BITS-1)-1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic [XLEN-1:0]     predict_pc,
    output logic                predict_taken,
    output logic [GHR_BITS-1:0] predict_ghr,
    input  logic                spec_push,
    input  logic                resolve_valid,
    input  logic [XLEN-1:0]     resolve_pc,
    input  logic [GHR_BITS-1:0] resolve_ghr,
    input  logic                resolve_taken,
    input  logic                resolve_mispredict,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_mispredicts
);

    localparam int IDX = $clog2(PHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT_V = CTR_BITS'(CTR_INIT);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e              state_q, state_d;
    logic [IDX-1:0]      ptr_q, ptr_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         br_q, br_d, mp_q, mp_d;
    logic [CTR_BITS-1:0] pht_q [PHT_ENTRIES];

    logic                run;
    logic [IDX-1:0]      pidx, uidx, wr_idx;
    logic [CTR_BITS-1:0] uctr, wr_val;
    logic                wr_en;
    logic                unused_pc_bits;

    assign run  = (state_q == S_RUN);
    assign pidx = predict_pc[IDX+1:2] ^ IDX'(ghr_q);
    assign uidx = resolve_pc[IDX+1:2] ^ IDX'(resolve_ghr);
    assign uctr = pht_q[uidx];

    assign ready            = run;
    assign predict_taken    = run & pht_q[pidx][CTR_BITS-1];
    assign predict_ghr      = ghr_q;
    assign perf_branches    = br_q;
    assign perf_mispredicts = mp_q;

    assign unused_pc_bits = ^{predict_pc[XLEN-1:IDX+2], predict_pc[1:0],
                              resolve_pc[XLEN-1:IDX+2], resolve_pc[1:0]};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        br_d    = br_q;
        mp_d    = mp_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        wr_val  = CTR_INIT_V;
        case (state_q)
            S_INIT: begin
                wr_en = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) state_d = S_RUN;
            end
            S_RUN: begin
                // Truncating cast of the concatenation shifts in the new bit and
                // also covers GHR_BITS == 1 without a negative slice.
                if (resolve_valid && resolve_mispredict)
                    ghr_d = GHR_BITS'({resolve_ghr, resolve_taken});
                else if (spec_push)
                    ghr_d = GHR_BITS'({ghr_q, predict_taken});
                if (resolve_valid) begin
                    wr_en  = 1'b1;
                    wr_idx = uidx;
                    if (resolve_taken)
                        wr_val = (uctr == CTR_MAX) ? uctr : uctr + 1'b1;
                    else
                        wr_val = (uctr == '0) ? uctr : uctr - 1'b1;
                    if (br_q != '1) br_d = br_q + 1'b1;
                    if (resolve_mispredict && (mp_q != '1)) mp_d = mp_q + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
            br_q    <= '0;
            mp_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
            br_q    <= br_d;
            mp_q    <= mp_d;
        end
    end

    // Table has no reset so it can map onto single-write-port RAM.
    always_ff @(posedge clk) begin
        if (wr_en) pht_q[wr_idx] <= wr_val;
    end

endmodule

// File: tb/tb_gshare_predictor_ghr.sv
// Self-checking bench for gshare_predictor_ghr: directed scenarios plus random
// traffic compared against an arithmetic reference model of the predictor.
module tb_gshare_predictor_ghr;

    localparam int XLEN        = 32;
    localparam int PHT_ENTRIES = 1024;
    localparam int GHR_BITS    = 10;
    localparam int CTR_BITS    = 2;
    localparam int CTR_INIT    = 1;
    localparam int CTR_MAX     = 3;
    localparam longint PERF_MAX = 64'hFFFF_FFFF;

    logic                clk = 1'b0;
    logic                reset;
    logic                ready;
    logic [XLEN-1:0]     predict_pc;
    logic                predict_taken;
    logic [GHR_BITS-1:0] predict_ghr;
    logic                spec_push;
    logic                resolve_valid;
    logic [XLEN-1:0]     resolve_pc;
    logic [GHR_BITS-1:0] resolve_ghr;
    logic                resolve_taken;
    logic                resolve_mispredict;
    logic [31:0]         perf_branches;
    logic [31:0]         perf_mispredicts;

    gshare_predictor_ghr #(
        .XLEN(XLEN), .PHT_ENTRIES(PHT_ENTRIES), .GHR_BITS(GHR_BITS),
        .CTR_BITS(CTR_BITS), .CTR_INIT(CTR_INIT)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .predict_pc(predict_pc), .predict_taken(predict_taken), .predict_ghr(predict_ghr),
        .spec_push(spec_push), .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_ghr(resolve_ghr), .resolve_taken(resolve_taken),
        .resolve_mispredict(resolve_mispredict),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int     m_pht [PHT_ENTRIES];
    int     m_ghr;
    int     m_init_cnt;
    longint m_br, m_mp;
    bit     m_known = 0;

    function automatic int m_idx(input logic [31:0] pc, input int g);
        return (int'(pc / 4) % PHT_ENTRIES) ^ g;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit rdy;
        bit pt;
        int ui;
        @(negedge clk);
        rdy = (m_init_cnt >= PHT_ENTRIES);
        pt  = rdy && (m_pht[m_idx(predict_pc, m_ghr)] >= 2**(CTR_BITS-1));
        if (!reset && m_known) begin
            check("ready", 32'(ready), 32'(rdy));
            check("predict_ghr", 32'(predict_ghr), rdy ? 32'(m_ghr) : 32'd0);
            check("predict_taken", 32'(predict_taken), 32'(pt));
            check("perf_branches", perf_branches, 32'(m_br));
            check("perf_mispredicts", perf_mispredicts, 32'(m_mp));
        end
        if (reset) begin
            m_known = 1; m_init_cnt = 0; m_ghr = 0; m_br = 0; m_mp = 0;
        end else if (m_known) begin
            if (!rdy) begin
                m_pht[m_init_cnt] = CTR_INIT;
                m_init_cnt++;
            end else begin
                if (resolve_valid) begin
                    ui = m_idx(resolve_pc, int'(resolve_ghr));
                    if (resolve_taken) m_pht[ui] = (m_pht[ui] + 1 > CTR_MAX) ? CTR_MAX : m_pht[ui] + 1;
                    else               m_pht[ui] = (m_pht[ui] - 1 < 0) ? 0 : m_pht[ui] - 1;
                    if (m_br < PERF_MAX) m_br++;
                    if (resolve_mispredict && m_mp < PERF_MAX) m_mp++;
                end
                if (resolve_valid && resolve_mispredict)
                    m_ghr = (int'(resolve_ghr) * 2 + int'(resolve_taken)) % (2**GHR_BITS);
                else if (spec_push)
                    m_ghr = (m_ghr * 2 + int'(pt)) % (2**GHR_BITS);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        spec_push = 0; resolve_valid = 0; resolve_mispredict = 0;
        resolve_taken = 0; resolve_pc = '0; resolve_ghr = '0;
    endtask

    task automatic randomize_inputs();
        predict_pc         = $urandom;
        spec_push          = 1'($urandom);
        resolve_valid      = 1'($urandom);
        resolve_pc         = $urandom;
        resolve_ghr        = GHR_BITS'($urandom);
        resolve_taken      = 1'($urandom);
        resolve_mispredict = ($urandom_range(0, 3) == 0);
    endtask

    task automatic resolve(input logic [31:0] pc, input int g, input bit t, input bit mis);
        resolve_valid = 1; resolve_pc = pc; resolve_ghr = GHR_BITS'(g);
        resolve_taken = t; resolve_mispredict = mis;
        step();
    endtask

    initial begin
        predict_pc = '0;
        quiet();
        // 1. init sweep, random traffic must be ignored
        reset = 1; step(); reset = 0;
        for (int k = 0; k < PHT_ENTRIES; k++) begin randomize_inputs(); step(); end
        #1 check("ready_after_sweep", 32'(ready), 32'd1);
        reset = 1; step(); reset = 0;
        for (int k = 0; k < 500; k++) begin randomize_inputs(); step(); end
        reset = 1; step(); reset = 0;
        for (int k = 0; k < PHT_ENTRIES - 1; k++) begin randomize_inputs(); step(); end
        #1 check("ready_last_init_cycle", 32'(ready), 32'd0);
        quiet(); step();
        #1 check("ready_restart_sweep", 32'(ready), 32'd1);
        check("ghr_after_init", 32'(predict_ghr), 32'd0);

        // 2. saturating training at index 0x40
        predict_pc = 32'h100;
        #1 check("t2_initial_nt", 32'(predict_taken), 32'd0);
        resolve(32'h100, 0, 1, 0);
        #1 check("t2_taken_after_1", 32'(predict_taken), 32'd1);
        resolve(32'h100, 0, 1, 0);
        resolve(32'h100, 0, 1, 0);
        resolve(32'h100, 0, 0, 0);
        #1 check("t2_still_taken_ctr2", 32'(predict_taken), 32'd1);
        resolve(32'h100, 0, 0, 0);
        #1 check("t2_nt_ctr1", 32'(predict_taken), 32'd0);
        resolve(32'h100, 0, 0, 0);
        quiet();
        #1 check("t2_nt_ctr0", 32'(predict_taken), 32'd0);

        // 3. hash indexing: move spec GHR to 0x040 via recovery, train index 0
        resolve(32'h300, 32'h020, 0, 1);
        resolve(32'h100, 32'h040, 1, 0);
        resolve(32'h100, 32'h040, 1, 0);
        quiet();
        #1 check("t3_ghr_040", 32'(predict_ghr), 32'h040);
        check("t3_hashed_taken", 32'(predict_taken), 32'd1);
        resolve(32'h300, 0, 0, 1);
        quiet();
        #1 check("t3_ghr_0", 32'(predict_ghr), 32'h000);
        check("t3_unhashed_nt", 32'(predict_taken), 32'd0);

        // 5. same-cycle read/write collision at index 0x60
        predict_pc = 32'h180;
        resolve_valid = 1; resolve_pc = 32'h180; resolve_ghr = '0;
        resolve_taken = 1; resolve_mispredict = 0;
        #1 check("t5_no_bypass", 32'(predict_taken), 32'd0);
        step();
        quiet();
        #1 check("t5_next_cycle", 32'(predict_taken), 32'd1);

        // 4. speculative history then recovery
        predict_pc = 32'h200;
        resolve(32'h200, 0, 1, 0);
        resolve(32'h200, 1, 1, 0);
        resolve(32'h200, 3, 1, 0);
        quiet();
        spec_push = 1;
        for (int k = 0; k < 3; k++) step();
        spec_push = 0;
        #1 check("t4_ghr_007", 32'(predict_ghr), 32'h007);
        spec_push = 1;
        resolve(32'h200, 1, 0, 1);
        quiet();
        #1 check("t4_recover_002", 32'(predict_ghr), 32'h002);

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin randomize_inputs(); step(); end
        quiet();

        // 6. perf counters
        reset = 1; step(); reset = 0;
        #1 check("t6_br_reset", perf_branches, 32'd0);
        check("t6_mp_reset", perf_mispredicts, 32'd0);
        for (int k = 0; k < PHT_ENTRIES; k++) step();
        resolve(32'h400, 5, 1, 1);
        resolve(32'h404, 6, 0, 0);
        resolve(32'h408, 7, 1, 0);
        resolve(32'h40c, 8, 0, 1);
        resolve(32'h410, 9, 1, 0);
        quiet();
        resolve_mispredict = 1; step();
        resolve_mispredict = 0;
        #1 check("t6_branches_5", perf_branches, 32'd5);
        check("t6_mispredicts_2", perf_mispredicts, 32'd2);
        force dut.br_q = 32'hFFFF_FFFF;
        force dut.mp_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_q;
        release dut.mp_q;
        m_br = PERF_MAX; m_mp = PERF_MAX;
        resolve(32'h500, 1, 1, 1);
        quiet();
        step();
        check("t6_br_saturate", perf_branches, 32'hFFFF_FFFF);
        check("t6_mp_saturate", perf_mispredicts, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gshare_predictor_ghr.md
Name: gshare_predictor_ghr

Overview:
Parametrised gshare conditional-branch direction predictor for the fetch stage. It keeps a speculative global history register (GHR) and provides a GHR snapshot for each prediction, which travels down the pipeline. On a mispredict it restores history from that snapshot. It trains the PHT using the same hashed index used at predict time, and initialises the PHT with a sweep FSM so the table can map to single-port-write RAM.

Parameters:
XLEN, 32, data/PC width
PHT_ENTRIES, 1024, counter table depth; power of two, >= 4
GHR_BITS, 10, history length; must be <= log2(PHT_ENTRIES)
CTR_BITS, 2, saturating counter width, 1..4
CTR_INIT, 2**(CTR_BITS-1)-1, post-init counter value (weakly not-taken)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
ready  out  1  table initialised; predictor operational
predict_pc  in  XLEN  fetch PC being predicted
predict_taken  out  1  predicted direction for predict_pc (combinational)
predict_ghr  out  GHR_BITS  current speculative GHR; the fetch packet attaches this as its snapshot
spec_push  in  1  fetch committed a conditional-branch prediction this cycle
resolve_valid  in  1  EX resolved a conditional branch
resolve_pc  in  XLEN  PC of the resolved branch
resolve_ghr  in  GHR_BITS  snapshot captured when that branch was predicted
resolve_taken  in  1  actual direction
resolve_mispredict  in  1  predicted direction was wrong
perf_branches  out  32  resolved-branch count
perf_mispredicts  out  32  mispredict count

Behaviour:
- IDX = log2(PHT_ENTRIES). Predict index = predict_pc[IDX+1:2] XOR zero-extended spec GHR. Update index = resolve_pc[IDX+1:2] XOR zero-extended resolve_ghr.
- FSM states INIT and RUN. Reset forces INIT with sweep pointer 0, spec GHR 0, and both perf counters 0.
- INIT: write CTR_INIT to entry[ptr] each cycle and increment ptr. After writing entry PHT_ENTRIES-1, go to RUN.
- ready = 0 in INIT and 1 in RUN. The first cycle with ready = 1 is exactly PHT_ENTRIES cycles after the reset-release cycle.
- While in INIT: predict_taken = 0, spec_push and resolve_valid are ignored, and predict_ghr = 0.
- Reset asserted in any state, including mid-sweep, restarts the sweep from ptr 0.
- predict_taken = MSB of entry[predict index]. No bypass: a same-cycle update to the same index is not visible until the next cycle.
- Spec GHR on spec_push: GHR <= {GHR[GHR_BITS-2:0], predict_taken}. When GHR_BITS = 1, GHR <= predict_taken.
- Recovery on resolve_valid & resolve_mispredict: GHR <= {resolve_ghr[GHR_BITS-2:0], resolve_taken}. Recovery takes priority over a same-cycle spec_push, which is dropped.
- PHT training on resolve_valid in RUN: the counter at the update index saturates.
  - Taken: ctr + 1, capped at 2**CTR_BITS-1.
  - Not taken: ctr - 1, floored at 0.
  - One write per cycle.
- Perf counters: each is +1 on resolve_valid (branches) or on resolve_valid & resolve_mispredict (mispredicts). Both saturate at 0xFFFFFFFF with no wrap.
- resolve_mispredict without resolve_valid has no effect.

Test Plan:
1. Init sweep: reset 1 cycle, then release → ready = 0 for 1024 cycles, ready = 1 on cycle 1024. Any predict_pc gives predict_taken = 0. Reasserting reset at sweep cycle 500 → ready stays 0 for a further full 1024 cycles.
2. Saturating training: with GHR snapshot 0, resolve pc 0x100 taken 3 times.
   - Entry 0x40 goes 1 → 2 → 3 → 3.
   - predict_pc 0x100 with spec GHR 0 → predict_taken = 1 after the first update.
   - Then 3 not-taken resolves → 2, 1, 0, and predict_taken = 0 from the second one onward.
3. Hash indexing: train pc 0x100 with ghr 0x040 (index 0x000) taken twice. Then predict pc 0x100 with spec GHR 0x040 → taken, and with spec GHR 0 (index 0x40, untrained) → not taken.
4. Speculative history and recovery:
   - 3 spec_push cycles with predict_taken = 1 → predict_ghr = 0x007.
   - Resolve mispredict with resolve_ghr 0x001, resolve_taken 0, plus spec_push in the same cycle → predict_ghr = 0x002 next cycle.
5. Read/write collision: entry X = 1; in the same cycle, predict and train taken at index X → predict_taken = 0 that cycle and 1 the next.
6. Perf counters: 5 resolves, 2 of them mispredicts → perf_branches = 5, perf_mispredicts = 2. After reset both are 0. Forcing both to 0xFFFFFFFF and resolving a mispredict → both hold 0xFFFFFFFF.
